tx_dma_usr_chan_stats: RTL



---
 rtl/tx_dma_stats_pkg.sv | 44 ++++
 rtl/tx_dma_stats_chan_adder.sv | 33 +++
 rtl/tx_dma_usr_chan_stats.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_dma_stats_pkg.sv
// Shared constants, types and helpers for the TX DMA user channel statistics.
// Holds the MI register offsets, the invalid-address pattern and counter math.
package tx_dma_stats_pkg;

    localparam logic [3:0] PKT_LO  = 4'h0;
    localparam logic [3:0] PKT_HI  = 4'h4;
    localparam logic [3:0] BYTE_LO = 4'h8;
    localparam logic [3:0] BYTE_HI = 4'hC;

    localparam logic [31:0] INVALID_RD = 32'hDEADCAFE;

    // Counters are kept 64 bits wide; bits above the configured width stay 0.
    typedef struct packed {
        logic [63:0] pkts;
        logic [63:0] bytes;
    } cntr_pair_t;

    function automatic int pkt_inc_w(input int regions);
        return $clog2(regions + 1);
    endfunction

    function automatic int byte_inc_w(input int regions, input int pkt_size_max);
        return $clog2(regions * pkt_size_max + 1);
    endfunction

    function automatic logic [63:0] cnt_wrap(
        input logic [63:0] cur,
        input logic [63:0] inc,
        input logic [63:0] mask
    );
        return (cur + inc) & mask;
    endfunction

    function automatic logic [63:0] cnt_sat(
        input logic [63:0] cur,
        input logic [63:0] inc,
        input logic [63:0] mask
    );
        logic [64:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        return (sum > {1'b0, mask}) ? mask : sum[63:0];
    endfunction

endpackage

// File: rtl/tx_dma_stats_chan_adder.sv
// Per-channel increment reduction: counts valid regions addressed to CHAN_ID
// and sums their sizes. Ports: vld_i/chan_i/size_i in, pkt_inc_o/byte_inc_o out.
module tx_dma_stats_chan_adder
    import tx_dma_stats_pkg::*;
#(
    parameter int REGIONS      = 1,
    parameter int CHAN_W       = 4,
    parameter int SIZE_W       = 13,
    parameter int PKT_SIZE_MAX = 4096,
    parameter int PKT_INC_W    = pkt_inc_w(REGIONS),
    parameter int BYTE_INC_W   = byte_inc_w(REGIONS, PKT_SIZE_MAX),
    parameter int CHAN_ID      = 0
) (
    input  logic [REGIONS-1:0]        vld_i,
    input  logic [REGIONS*CHAN_W-1:0] chan_i,
    input  logic [REGIONS*SIZE_W-1:0] size_i,
    output logic [PKT_INC_W-1:0]      pkt_inc_o,
    output logic [BYTE_INC_W-1:0]     byte_inc_o
);

    always_comb begin
        pkt_inc_o  = '0;
        byte_inc_o = '0;
        for (int r = 0; r < REGIONS; r++) begin
            if (vld_i[r] && (chan_i[r*CHAN_W +: CHAN_W] == CHAN_W'(CHAN_ID))) begin
                pkt_inc_o  = pkt_inc_o + PKT_INC_W'(1);
                byte_inc_o = byte_inc_o
                           + BYTE_INC_W'(size_i[r*SIZE_W +: SIZE_W]);
            end
        end
    end

endmodule

// File: rtl/tx_dma_usr_chan_stats.sv
// Snoops USR TX MFB SOFs and keeps per-channel 64-bit packet/byte counters,
// read and cleared over MI. Ports: CLK, RESET, USR_MFB_* (snoop), MI_* (bus).
// Macro TX_DMA_STATS_SATURATE_EN: counters saturate, sticky flag in pkt hi bit 31.
module tx_dma_usr_chan_stats
    import tx_dma_stats_pkg::*;
#(
    parameter int REGIONS      = 1,
    parameter int CHANNELS     = 16,
    parameter int PKT_SIZE_MAX = 2**12,
    parameter int CNTRS_WIDTH  = 64,
    parameter int MI_WIDTH     = 32
) (
    input  logic                                        CLK,
    input  logic                                        RESET,
    input  logic [REGIONS-1:0]                          USR_MFB_SOF,
    input  logic [REGIONS*$clog2(PKT_SIZE_MAX+1)-1:0]   USR_MFB_META_PKT_SIZE,
    input  logic [REGIONS*$clog2(CHANNELS)-1:0]         USR_MFB_META_CHAN,
    input  logic                                        USR_MFB_SRC_RDY,
    input  logic                                        USR_MFB_DST_RDY,
    input  logic [MI_WIDTH-1:0]                         MI_ADDR,
    input  logic [MI_WIDTH-1:0]                         MI_DWR,
    input  logic [MI_WIDTH/8-1:0]                       MI_BE,
    input  logic                                        MI_RD,
    input  logic                                        MI_WR,
    output logic [MI_WIDTH-1:0]                         MI_DRD,
    output logic                                        MI_ARDY,
    output logic                                        MI_DRDY
);

    localparam int SIZE_W     = $clog2(PKT_SIZE_MAX + 1);
    localparam int CHAN_W     = $clog2(CHANNELS);
    localparam int PKT_INC_W  = pkt_inc_w(REGIONS);
    localparam int BYTE_INC_W = byte_inc_w(REGIONS, PKT_SIZE_MAX);
    localparam logic [63:0] CNT_MASK = {64{1'b1}} >> (64 - CNTRS_WIDTH);

    // Stage 1: registered snoop of the handshaked SOFs and their metadata
    logic [REGIONS-1:0]        s1_vld_q, s1_vld_d;
    logic [REGIONS*CHAN_W-1:0] s1_chan_q;
    logic [REGIONS*SIZE_W-1:0] s1_size_q;

    assign s1_vld_d = USR_MFB_SOF
                    & {REGIONS{USR_MFB_SRC_RDY & USR_MFB_DST_RDY}};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_vld_q  <= '0;
            s1_chan_q <= '0;
            s1_size_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_chan_q <= USR_MFB_META_CHAN;
            s1_size_q <= USR_MFB_META_PKT_SIZE;
        end
    end

    // MI address decode shared by the read and clear paths
    logic              addr_ok;
    logic [CHAN_W-1:0] mi_ch;
    logic [3:0]        mi_off;

    assign addr_ok = (MI_ADDR[MI_WIDTH-1:CHAN_W+4] == '0);
    assign mi_ch   = MI_ADDR[CHAN_W+3:4];
    assign mi_off  = {MI_ADDR[3:2], 2'b00};

    cntr_pair_t          cnt_rd [CHANNELS];
    logic [CHANNELS-1:0] flag_rd;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [PKT_INC_W-1:0]  add_pkt, s2_pkt_q;
        logic [BYTE_INC_W-1:0] add_byte, s2_byte_q;
        logic                  clr;
        cntr_pair_t            cnt_q, cnt_d;

        tx_dma_stats_chan_adder #(
            .REGIONS      (REGIONS),
            .CHAN_W       (CHAN_W),
            .SIZE_W       (SIZE_W),
            .PKT_SIZE_MAX (PKT_SIZE_MAX),
            .PKT_INC_W    (PKT_INC_W),
            .BYTE_INC_W   (BYTE_INC_W),
            .CHAN_ID      (c)
        ) u_adder (
            .vld_i      (s1_vld_q),
            .chan_i     (s1_chan_q),
            .size_i     (s1_size_q),
            .pkt_inc_o  (add_pkt),
            .byte_inc_o (add_byte)
        );

        assign clr = MI_WR && addr_ok
                   && (mi_ch == CHAN_W'(c)) && (mi_off == PKT_LO);

`ifdef TX_DMA_STATS_SATURATE_EN
        logic flag_q, flag_d;

        always_comb begin
            cnt_d.pkts  = cnt_sat(cnt_q.pkts, 64'(s2_pkt_q), CNT_MASK);
            cnt_d.bytes = cnt_sat(cnt_q.bytes, 64'(s2_byte_q), CNT_MASK);
            flag_d      = flag_q | (cnt_d.pkts == CNT_MASK);
            // Clear beats the increment landing in the same cycle
            if (clr) begin
                cnt_d  = '0;
                flag_d = 1'b0;
            end
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                flag_q <= 1'b0;
            end else begin
                flag_q <= flag_d;
            end
        end

        assign flag_rd[c] = flag_q;
`else
        always_comb begin
            cnt_d.pkts  = cnt_wrap(cnt_q.pkts, 64'(s2_pkt_q), CNT_MASK);
            cnt_d.bytes = cnt_wrap(cnt_q.bytes, 64'(s2_byte_q), CNT_MASK);
            // Clear beats the increment landing in the same cycle
            if (clr) begin
                cnt_d = '0;
            end
        end

        assign flag_rd[c] = 1'b0;
`endif

        // Stage 2 increment register, then counter accumulate
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                s2_pkt_q  <= '0;
                s2_byte_q <= '0;
                cnt_q     <= '0;
            end else begin
                s2_pkt_q  <= add_pkt;
                s2_byte_q <= add_byte;
                cnt_q     <= cnt_d;
            end
        end

        assign cnt_rd[c] = cnt_q;
    end

    // MI read path with a single high-word shadow for atomic lo/hi pairs
    cntr_pair_t  rd_sel;
    logic [31:0] pkt_hi_w, byte_hi_w;
    logic [31:0] drd_q, drd_d;
    logic [31:0] shadow_q, shadow_d;
    logic        drdy_q;

    assign rd_sel    = cnt_rd[mi_ch];
    assign pkt_hi_w  = rd_sel.pkts[63:32] | {flag_rd[mi_ch], 31'b0};
    assign byte_hi_w = rd_sel.bytes[63:32];

    always_comb begin
        drd_d    = '0;
        shadow_d = shadow_q;
        if (MI_RD) begin
            if (!addr_ok) begin
                drd_d = INVALID_RD;
            end else begin
                case (mi_off)
                    PKT_LO: begin
                        drd_d    = rd_sel.pkts[31:0];
                        shadow_d = pkt_hi_w;
                    end
                    BYTE_LO: begin
                        drd_d    = rd_sel.bytes[31:0];
                        shadow_d = byte_hi_w;
                    end
                    default: begin
                        drd_d = shadow_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            drdy_q   <= 1'b0;
            drd_q    <= '0;
            shadow_q <= '0;
        end else begin
            drdy_q   <= MI_RD;
            drd_q    <= drd_d;
            shadow_q <= shadow_d;
        end
    end

    assign MI_ARDY = MI_RD | MI_WR;
    assign MI_DRDY = drdy_q;
    assign MI_DRD  = drd_q;

    // Write data, byte enables and sub-word address bits carry no meaning here
    logic unused_mi;
    assign unused_mi = ^{MI_DWR, MI_BE, MI_ADDR[1:0]};

endmodule
